// File: rtl/elevator_car_ctrl.sv
// Single elevator car: latches hall/car requests, runs a LOOK scan, and drives
// the motor command and door with cycle-counted travel and dwell times.
module elevator_car_ctrl #(
   parameter int NFLOOR     = 11,
   parameter int TRAVEL_CYC = 4,
   parameter int DOOR_CYC   = 3,
   parameter int FW         = $clog2(NFLOOR)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NFLOOR-1:0] hall_up,
   input  logic [NFLOOR-1:0] hall_dn,
   input  logic [NFLOOR-1:0] car_req,
   output logic [1:0]        motor_signal,
   output logic              door_open,
   output logic [FW-1:0]     cur_floor,
   output logic              dir_up,
   output logic [NFLOOR-1:0] pend_up,
   output logic [NFLOOR-1:0] pend_dn,
   output logic [NFLOOR-1:0] pend_car,
   output logic              busy
);

   localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
   localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
   localparam logic [NFLOOR-1:0] UP_MASK = {1'b0, {(NFLOOR-1){1'b1}}};
   localparam logic [NFLOOR-1:0] DN_MASK = {{(NFLOOR-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

   state_t            state_q, state_d;
   logic [FW-1:0]     cur_floor_q, cur_floor_d;
   logic              dir_up_q, dir_up_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic [DW-1:0]     dcnt_q, dcnt_d;
   logic [NFLOOR-1:0] pend_up_q, pend_up_d;
   logic [NFLOOR-1:0] pend_dn_q, pend_dn_d;
   logic [NFLOOR-1:0] pend_car_q, pend_car_d;

   logic [NFLOOR-1:0] in_up, in_dn;
   logic [NFLOOR-1:0] req_up, req_dn, req_car, req_all, pend_all;
   logic [FW-1:0]     arr_floor, door_f;
   logic              enter_door;

   function automatic logic any_beyond(input logic [NFLOOR-1:0] r,
                                       input logic [FW-1:0] f,
                                       input logic up);
      any_beyond = 1'b0;
      for (int i = 0; i < NFLOOR; i++) begin
         if (up ? (i > int'(f)) : (i < int'(f))) any_beyond = any_beyond | r[i];
      end
   endfunction

   // Stop at f for car calls, same-direction hall calls, or any hall call at the scan end.
   function automatic logic stop_at(input logic [NFLOOR-1:0] up_v,
                                    input logic [NFLOOR-1:0] dn_v,
                                    input logic [NFLOOR-1:0] car_v,
                                    input logic [FW-1:0] f,
                                    input logic up);
      logic ahead;
      ahead   = any_beyond(up_v | dn_v | car_v, f, up);
      stop_at = car_v[f] | (up ? up_v[f] : dn_v[f]) | (!ahead & (up_v[f] | dn_v[f]));
   endfunction

   always_comb begin
      in_up    = hall_up & UP_MASK;
      in_dn    = hall_dn & DN_MASK;
      req_up   = pend_up_q | in_up;
      req_dn   = pend_dn_q | in_dn;
      req_car  = pend_car_q | car_req;
      req_all  = req_up | req_dn | req_car;
      pend_all = pend_up_q | pend_dn_q | pend_car_q;

      state_d     = state_q;
      cur_floor_d = cur_floor_q;
      dir_up_d    = dir_up_q;
      tcnt_d      = tcnt_q;
      dcnt_d      = dcnt_q;
      pend_up_d   = req_up;
      pend_dn_d   = req_dn;
      pend_car_d  = req_car;
      enter_door  = 1'b0;
      door_f      = cur_floor_q;
      arr_floor   = dir_up_q ? cur_floor_q + FW'(1) : cur_floor_q - FW'(1);

      case (state_q)
         IDLE: begin
            if (stop_at(pend_up_q, pend_dn_q, pend_car_q, cur_floor_q, dir_up_q)) begin
               enter_door = 1'b1;
            end else if (any_beyond(pend_all, cur_floor_q, dir_up_q)) begin
               state_d = MOVE;
               tcnt_d  = '0;
            end else if (any_beyond(pend_all, cur_floor_q, !dir_up_q)) begin
               dir_up_d = !dir_up_q;
               state_d  = MOVE;
               tcnt_d   = '0;
            end
         end
         MOVE: begin
            if (tcnt_q == TW'(TRAVEL_CYC - 1)) begin
               tcnt_d      = '0;
               cur_floor_d = arr_floor;
               if (stop_at(req_up, req_dn, req_car, arr_floor, dir_up_q)) begin
                  enter_door = 1'b1;
                  door_f     = arr_floor;
               end
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         DOOR: begin
            // Calls at the open floor are absorbed as a door reopen, never latched.
            pend_up_d[cur_floor_q]  = pend_up_q[cur_floor_q];
            pend_dn_d[cur_floor_q]  = pend_dn_q[cur_floor_q];
            pend_car_d[cur_floor_q] = pend_car_q[cur_floor_q];
            if (car_req[cur_floor_q] | in_up[cur_floor_q] | in_dn[cur_floor_q]) begin
               dcnt_d = '0;
            end else if (dcnt_q == DW'(DOOR_CYC - 1)) begin
               state_d = IDLE;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (enter_door) begin
         state_d            = DOOR;
         dcnt_d             = '0;
         pend_car_d[door_f] = 1'b0;
         if (dir_up_q) pend_up_d[door_f] = 1'b0;
         else          pend_dn_d[door_f] = 1'b0;
         if (!any_beyond(req_all, door_f, dir_up_q)) begin
            pend_up_d[door_f] = 1'b0;
            pend_dn_d[door_f] = 1'b0;
            if (any_beyond(req_all, door_f, !dir_up_q)) dir_up_d = !dir_up_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_floor_q <= '0;
         dir_up_q    <= 1'b1;
         tcnt_q      <= '0;
         dcnt_q      <= '0;
         pend_up_q   <= '0;
         pend_dn_q   <= '0;
         pend_car_q  <= '0;
      end else begin
         state_q     <= state_d;
         cur_floor_q <= cur_floor_d;
         dir_up_q    <= dir_up_d;
         tcnt_q      <= tcnt_d;
         dcnt_q      <= dcnt_d;
         pend_up_q   <= pend_up_d;
         pend_dn_q   <= pend_dn_d;
         pend_car_q  <= pend_car_d;
      end
   end

   always_comb begin
      motor_signal = 2'b00;
      if (state_q == MOVE) motor_signal = dir_up_q ? 2'b01 : 2'b10;
   end

   assign door_open = (state_q == DOOR);
   assign cur_floor = cur_floor_q;
   assign dir_up    = dir_up_q;
   assign pend_up   = pend_up_q;
   assign pend_dn   = pend_dn_q;
   assign pend_car  = pend_car_q;
   assign busy      = (state_q != IDLE) | (|pend_all);

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Scoreboard bench for elevator_car_ctrl: expected per-cycle motor/door/floor/busy
// values are queued with each stimulus and popped as the car runs.
module tb_elevator_car_ctrl;

   localparam int NFLOOR = 11;
   localparam int FW     = $clog2(NFLOOR);

   logic              clk;
   logic              rst;
   logic [NFLOOR-1:0] hall_up, hall_dn, car_req;
   logic [1:0]        motor_signal;
   logic              door_open;
   logic [FW-1:0]     cur_floor;
   logic              dir_up;
   logic [NFLOOR-1:0] pend_up, pend_dn, pend_car;
   logic              busy;

   typedef struct {
      logic [1:0]    motor;
      logic          door;
      logic [FW-1:0] floor;
      logic          busy;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   elevator_car_ctrl #(.NFLOOR(NFLOOR), .TRAVEL_CYC(4), .DOOR_CYC(3)) dut (
      .clk(clk), .rst(rst), .hall_up(hall_up), .hall_dn(hall_dn), .car_req(car_req),
      .motor_signal(motor_signal), .door_open(door_open), .cur_floor(cur_floor),
      .dir_up(dir_up), .pend_up(pend_up), .pend_dn(pend_dn), .pend_car(pend_car),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [1:0] m, input logic d, input int f,
                       input logic b, input int n);
      exp_t x;
      x.motor = m; x.door = d; x.floor = FW'(f); x.busy = b;
      for (int i = 0; i < n; i++) sb.push_back(x);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      push(2'b00, 1'b0, 0, 1'b0, 1);
      tick();
      rst = 1'b0;
      e = sb.pop_front();
      checks++;
      if (motor_signal !== e.motor || door_open !== e.door || cur_floor !== e.floor || busy !== e.busy) begin
         errors++;
         $display("FAIL reset: got m=%b d=%b f=%0d b=%b want m=%b d=%b f=%0d b=%b",
                  motor_signal, door_open, cur_floor, busy, e.motor, e.door, e.floor, e.busy);
      end
      checks++;
      if (dir_up !== 1'b1 || pend_up !== '0 || pend_dn !== '0 || pend_car !== '0) begin
         errors++;
         $display("FAIL reset_state: got dir=%b up=%h dn=%h car=%h want dir=1 pend=0",
                  dir_up, pend_up, pend_dn, pend_car);
      end
   endtask

   task automatic test_door_here();
      hall_up = 11'd1;
      tick();
      hall_up = '0;
      checks++;
      if (pend_up !== 11'd1 || motor_signal !== 2'b00 || door_open !== 1'b0) begin
         errors++;
         $display("FAIL door_here_latch: got up=%h m=%b d=%b want up=001 m=00 d=0",
                  pend_up, motor_signal, door_open);
      end
      push(2'b00, 1'b1, 0, 1'b1, 3);
      push(2'b00, 1'b0, 0, 1'b0, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if (motor_signal !== e.motor || door_open !== e.door || cur_floor !== e.floor || busy !== e.busy) begin
            errors++;
            $display("FAIL door_here cyc %0d: got m=%b d=%b f=%0d b=%b want m=%b d=%b f=%0d b=%b",
                     i, motor_signal, door_open, cur_floor, busy, e.motor, e.door, e.floor, e.busy);
         end
      end
      checks++;
      if (pend_up !== '0) begin
         errors++;
         $display("FAIL door_here_clear: got up=%h want 000", pend_up);
      end
   endtask

   task automatic test_single_trip();
      car_req = 11'd1 << 3;
      tick();
      car_req = '0;
      checks++;
      if (pend_car !== 11'h008 || motor_signal !== 2'b00 || busy !== 1'b1) begin
         errors++;
         $display("FAIL trip_latch: got car=%h m=%b b=%b want car=008 m=00 b=1",
                  pend_car, motor_signal, busy);
      end
      for (int fl = 0; fl < 3; fl++) push(2'b01, 1'b0, fl, 1'b1, 4);
      push(2'b00, 1'b1, 3, 1'b1, 3);
      push(2'b00, 1'b0, 3, 1'b0, 1);
      for (int i = 0; i < 16; i++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if (motor_signal !== e.motor || door_open !== e.door || cur_floor !== e.floor || busy !== e.busy) begin
            errors++;
            $display("FAIL trip cyc %0d: got m=%b d=%b f=%0d b=%b want m=%b d=%b f=%0d b=%b",
                     i, motor_signal, door_open, cur_floor, busy, e.motor, e.door, e.floor, e.busy);
         end
      end
      checks++;
      if (pend_car !== '0 || dir_up !== 1'b1) begin
         errors++;
         $display("FAIL trip_end: got car=%h dir=%b want car=000 dir=1", pend_car, dir_up);
      end
   endtask

   task automatic test_reopen();
      car_req = 11'd1 << 3;
      tick();
      car_req = '0;
      checks++;
      if (pend_car !== 11'h008 || door_open !== 1'b0) begin
         errors++;
         $display("FAIL reopen_latch: got car=%h d=%b want car=008 d=0", pend_car, door_open);
      end
      push(2'b00, 1'b1, 3, 1'b1, 5);
      push(2'b00, 1'b0, 3, 1'b0, 1);
      for (int i = 0; i < 6; i++) begin
         if (i == 2) car_req = 11'd1 << 3;
         tick();
         car_req = '0;
         e = sb.pop_front();
         checks++;
         if (motor_signal !== e.motor || door_open !== e.door || cur_floor !== e.floor || busy !== e.busy) begin
            errors++;
            $display("FAIL reopen cyc %0d: got m=%b d=%b f=%0d b=%b want m=%b d=%b f=%0d b=%b",
                     i, motor_signal, door_open, cur_floor, busy, e.motor, e.door, e.floor, e.busy);
         end
         if (i == 2) begin
            checks++;
            if (pend_car !== '0) begin
               errors++;
               $display("FAIL reopen_nolatch: got car=%h want 000", pend_car);
            end
         end
      end
   endtask

   task automatic test_pass_through();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      car_req = 11'd1 << 8;
      tick();
      car_req = '0;
      for (int fl = 0; fl < 6; fl++) push(2'b01, 1'b0, fl, 1'b1, 4);
      push(2'b00, 1'b1, 6, 1'b1, 3);
      push(2'b00, 1'b0, 6, 1'b1, 1);
      push(2'b01, 1'b0, 6, 1'b1, 4);
      push(2'b01, 1'b0, 7, 1'b1, 4);
      push(2'b00, 1'b1, 8, 1'b1, 3);
      push(2'b00, 1'b0, 8, 1'b1, 1);
      push(2'b10, 1'b0, 8, 1'b1, 4);
      push(2'b10, 1'b0, 7, 1'b1, 4);
      push(2'b10, 1'b0, 6, 1'b1, 4);
      push(2'b00, 1'b1, 5, 1'b1, 3);
      push(2'b00, 1'b0, 5, 1'b0, 1);
      for (int i = 0; i < 56; i++) begin
         if (i == 0) begin
            hall_dn = 11'd1 << 5;
            hall_up = 11'd1 << 6;
         end
         tick();
         hall_dn = '0;
         hall_up = '0;
         e = sb.pop_front();
         checks++;
         if (motor_signal !== e.motor || door_open !== e.door || cur_floor !== e.floor || busy !== e.busy) begin
            errors++;
            $display("FAIL pass cyc %0d: got m=%b d=%b f=%0d b=%b want m=%b d=%b f=%0d b=%b",
                     i, motor_signal, door_open, cur_floor, busy, e.motor, e.door, e.floor, e.busy);
         end
         if (i == 0) begin
            checks++;
            if (pend_dn !== 11'h020 || pend_up !== 11'h040) begin
               errors++;
               $display("FAIL pass_latch: got dn=%h up=%h want dn=020 up=040", pend_dn, pend_up);
            end
         end
         if (i == 24) begin
            checks++;
            if (pend_up !== '0 || pend_dn !== 11'h020) begin
               errors++;
               $display("FAIL pass_stop6: got up=%h dn=%h want up=000 dn=020", pend_up, pend_dn);
            end
         end
         if (i == 36) begin
            checks++;
            if (dir_up !== 1'b0) begin
               errors++;
               $display("FAIL pass_reverse: got dir=%b want 0", dir_up);
            end
         end
      end
      checks++;
      if (dir_up !== 1'b0 || pend_up !== '0 || pend_dn !== '0 || pend_car !== '0) begin
         errors++;
         $display("FAIL pass_end: got dir=%b up=%h dn=%h car=%h want dir=0 pend=0",
                  dir_up, pend_up, pend_dn, pend_car);
      end
   endtask

   task automatic test_reset_mid_move();
      car_req = 11'd1 << 1;
      tick();
      car_req = '0;
      push(2'b10, 1'b0, 5, 1'b1, 3);
      for (int i = 0; i < 3; i++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if (motor_signal !== e.motor || door_open !== e.door || cur_floor !== e.floor || busy !== e.busy) begin
            errors++;
            $display("FAIL midmove cyc %0d: got m=%b d=%b f=%0d b=%b want m=%b d=%b f=%0d b=%b",
                     i, motor_signal, door_open, cur_floor, busy, e.motor, e.door, e.floor, e.busy);
         end
      end
      rst = 1'b1;
      push(2'b00, 1'b0, 0, 1'b0, 2);
      for (int i = 0; i < 2; i++) begin
         tick();
         rst = 1'b0;
         e = sb.pop_front();
         checks++;
         if (motor_signal !== e.motor || door_open !== e.door || cur_floor !== e.floor || busy !== e.busy) begin
            errors++;
            $display("FAIL midreset cyc %0d: got m=%b d=%b f=%0d b=%b want m=%b d=%b f=%0d b=%b",
                     i, motor_signal, door_open, cur_floor, busy, e.motor, e.door, e.floor, e.busy);
         end
         checks++;
         if (dir_up !== 1'b1 || pend_up !== '0 || pend_dn !== '0 || pend_car !== '0) begin
            errors++;
            $display("FAIL midreset_state cyc %0d: got dir=%b up=%h dn=%h car=%h want dir=1 pend=0",
                     i, dir_up, pend_up, pend_dn, pend_car);
         end
      end
   endtask

   task automatic test_ignored_bits();
      hall_up = 11'd1 << (NFLOOR - 1);
      hall_dn = 11'd1;
      push(2'b00, 1'b0, 0, 1'b0, 4);
      for (int i = 0; i < 4; i++) begin
         tick();
         hall_up = '0;
         hall_dn = '0;
         e = sb.pop_front();
         checks++;
         if (motor_signal !== e.motor || door_open !== e.door || cur_floor !== e.floor || busy !== e.busy) begin
            errors++;
            $display("FAIL ignored cyc %0d: got m=%b d=%b f=%0d b=%b want m=%b d=%b f=%0d b=%b",
                     i, motor_signal, door_open, cur_floor, busy, e.motor, e.door, e.floor, e.busy);
         end
      end
      checks++;
      if (pend_up !== '0 || pend_dn !== '0) begin
         errors++;
         $display("FAIL ignored_pend: got up=%h dn=%h want 000", pend_up, pend_dn);
      end
   endtask

   initial begin
      rst     = 1'b1;
      hall_up = '0;
      hall_dn = '0;
      car_req = '0;
      test_reset();
      test_door_here();
      test_single_trip();
      test_reopen();
      test_pass_through();
      test_reset_mid_move();
      test_ignored_bits();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
Parametrised single-car controller, the per-car building block behind the multi-car elevator_system. It latches hall and in-car requests and runs a LOOK scan: it keeps direction while requests lie ahead, and reverses or idles otherwise. It drives one 2-bit motor command and a door-open output, and counts travel and door-dwell time in clock cycles. Latched request vectors are exported so a group dispatcher can observe pending work.

Parameters:
NFLOOR, 11, number of floors (floors 0..NFLOOR-1), min 2
TRAVEL_CYC, 4, clock cycles to travel one floor, min 1
DOOR_CYC, 3, clock cycles the door stays open per stop, min 1
FW, $clog2(NFLOOR), floor index width (derived, do not override)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
hall_up  in  NFLOOR  hall up-call pulses/levels per floor; bit NFLOOR-1 ignored
hall_dn  in  NFLOOR  hall down-call per floor; bit 0 ignored
car_req  in  NFLOOR  in-car floor buttons
motor_signal  out  2  00 stop, 01 up, 10 down, 11 never driven
door_open  out  1  door open
cur_floor  out  FW  current/last-passed floor
dir_up  out  1  scan direction, 1 = up
pend_up, pend_dn, pend_car  out  NFLOOR each  latched requests
busy  out  1  state != IDLE or any pending bit set

Behaviour:
- Reset (rst high at an edge): state IDLE, cur_floor 0, dir_up 1, motor_signal 00, door_open 0, all pend 0, counters 0. Reset wins over every other event, including mid-MOVE or mid-DOOR.
- Latching: pend_x <= pend_x | x on every edge, except in the clear cases below. Ignored bits (hall_up[NFLOOR-1], hall_dn[0]) are never set.
- ahead = any pending bit (all three vectors) at floors beyond cur_floor in dir_up; behind = the same for the opposite side.
- States:
  - IDLE:
    - If any pend bit at cur_floor is set, go to DOOR.
    - Else if ahead is set, go to MOVE in the current direction.
    - Else if behind is set, flip dir_up and go to MOVE.
    - Else stay; motor 00.
  - MOVE:
    - motor_signal = 01 or 10 per dir_up. The travel counter runs 0..TRAVEL_CYC-1.
    - On the edge where the counter equals TRAVEL_CYC-1, cur_floor moves ±1 and the counter resets.
    - Stop test at arrival floor f, using pend values plus same-cycle inputs: stop if car_req[f], or hall in dir at f, or (no ahead beyond f and any hall at f). On stop, go to DOOR and motor 00 from that edge; otherwise continue.
    - cur_floor never leaves 0..NFLOOR-1. A request beyond the end cannot exist, so no saturation is needed.
  - DOOR:
    - door_open = 1 for exactly DOOR_CYC cycles, then go to IDLE.
    - On DOOR entry, clear pend_car[f] and the hall bit matching dir_up. If no ahead remains, also clear the opposite hall bit at f, and flip dir_up if behind is set.
    - Any car_req[f] or hall request at f asserted during DOOR is not latched; it reloads the dwell counter (door reopen).
- Latency: request sampled at edge E0 is visible on pend at E0. Motor leaves 00 at edge E1 (one edge later) when the car is idle.
- Door opening at the current floor from IDLE: door_open rises at E1.
- Motor and door are mutually exclusive: door_open=1 implies motor_signal=00.

Test Plan:
- Reset then car_req[3] pulse at E0 (TRAVEL_CYC=4, DOOR_CYC=3) -> motor 01 from E1; cur_floor 1,2,3 at E1+4, +8, +12; motor 00 and door_open=1 from E1+12 for 3 cycles; pend_car all 0; IDLE, busy 0.
- Idle at floor 0, hall_up[0] pulse -> door_open at E1 for 3 cycles; motor stays 00; cur_floor 0.
- Car at 0, car_req[8] pulse, then hall_dn[5] and hall_up[6] while the car is below 5 -> car passes 5 without stopping, stops at 6 (clears pend_up[6]), stops at 8, reverses, stops at 5, clears pend_dn[5], ends IDLE with dir_up 0.
- Door dwelling at 3, car_req[3] re-asserted on the 2nd door cycle -> door_open stays high 3 more cycles (4 total from reopen); pend_car[3] stays 0.
- Reset asserted mid-MOVE between floors 4 and 5 -> next edge: cur_floor 0, motor 00, pend all 0, dir_up 1.
- hall_up[NFLOOR-1] and hall_dn[0] pulses -> no pend bits set, busy stays 0, motor 00.
